// File: rtl/sobel_pkg.sv
// sobel_pkg -- shared types and default sizes for the Sobel pixel pipeline.
//
// Contents:
//   prm_state_t     : pixel_read_master state encoding (IDLE, ISSUE, DRAIN, DONE)
//   PIX_ADDR_W      : default pixel address width
//   PIX_DATA_W      : default pixel word width
//   PIX_FIFO_DEPTH  : default pixel buffer depth (power of 2, at least 2)
`timescale 1ns/1ps
package sobel_pkg;

    localparam int PIX_ADDR_W     = 32;
    localparam int PIX_DATA_W     = 32;
    localparam int PIX_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } prm_state_t;

endpackage

// File: rtl/pixel_read_master_if.sv
// pixel_read_master_if -- groups the Avalon-MM read master bus and the outgoing
// pixel stream of pixel_read_master.
//
// Signals:
//   m_address, m_read          : read request (master -> memory)
//   m_waitrequest, m_readdata  : stall and read data (memory -> master)
//   pix_data, pix_valid        : pixel stream (master -> Sobel stage)
//   pix_ready                  : stream back-pressure (Sobel stage -> master)
// Modports:
//   master : the view used by pixel_read_master
//   slave  : the view of the surrounding memory and Sobel stage
`timescale 1ns/1ps
interface pixel_read_master_if
    import sobel_pkg::*;
#(
    parameter int ADDR_W = PIX_ADDR_W,
    parameter int DATA_W = PIX_DATA_W
);
    logic [ADDR_W-1:0] m_address;
    logic              m_read;
    logic              m_waitrequest;
    logic [DATA_W-1:0] m_readdata;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;

    modport master (
        output m_address, m_read, pix_data, pix_valid,
        input  m_waitrequest, m_readdata, pix_ready
    );

    modport slave (
        input  m_address, m_read, pix_data, pix_valid,
        output m_waitrequest, m_readdata, pix_ready
    );
endinterface

// File: rtl/pixel_fifo.sv
// pixel_fifo -- small synchronous FIFO buffering pixel words between the
// memory reads and the pixel stream.
//
// Ports:
//   clk, rst : clock and synchronous active-high reset (also used as flush)
//   push     : write wdata (ignored when full unless a pop happens too)
//   pop      : remove head entry (ignored when empty)
//   rdata    : head entry, driven straight from storage flops
//   empty, full, count : occupancy, all derived from the count register
`timescale 1ns/1ps
module pixel_fifo
    import sobel_pkg::*;
#(
    parameter int DATA_W = PIX_DATA_W,
    parameter int DEPTH  = PIX_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [DATA_W-1:0]      wdata,
    input  logic                   pop,
    output logic [DATA_W-1:0]      rdata,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    // Next-state for storage, pointers and count. Pointers wrap naturally
    // because DEPTH is a power of 2. A push while full is only honoured
    // when a pop frees a slot in the same cycle.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Storage is cleared on reset so the head reads as zero when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;
endmodule

// File: rtl/pixel_read_master.sv
// pixel_read_master -- reads a range of pixel words over Avalon-MM and streams
// them to the Sobel stage through a small FIFO.
//
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   startpixel, endpixel : inclusive address range, latched on start
//   control              : bit0 = run (start on rise, abort when dropped)
//   bus                  : pixel_read_master_if.master (Avalon read + stream)
//   busy, done, err      : status flags
//   pix_count            : popped-pixel counter, only with PIXEL_COUNT_EN
// Build option:
//   PIXEL_COUNT_EN : adds the saturating pix_count output
`timescale 1ns/1ps
module pixel_read_master
    import sobel_pkg::*;
#(
    parameter int ADDR_W     = PIX_ADDR_W,
    parameter int DATA_W     = PIX_DATA_W,
    parameter int FIFO_DEPTH = PIX_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    startpixel,
    input  logic [ADDR_W-1:0]    endpixel,
    input  logic [31:0]          control,
    pixel_read_master_if.master  bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err
`ifdef PIXEL_COUNT_EN
    ,
    output logic [31:0]          pix_count
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    prm_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic              read_q, read_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              run, accept, pending, flush, start;
    logic              fifo_push, fifo_pop, fifo_empty, fifo_full, fifo_rst;
    logic [DATA_W-1:0] fifo_rdata;
    logic [CNT_W-1:0]  fifo_count, count_after;
    logic              unused_bits;

    assign unused_bits = ^{control[31:1], fifo_full};

    // Sequencing. An abort only lands once no read is outstanding; a read
    // accepted in the abort cycle is dropped rather than pushed. m_read for
    // the next cycle looks ahead at the FIFO occupancy after this edge so a
    // request is never raised without a free slot to receive it.
    always_comb begin
        run       = control[0];
        accept    = read_q && !bus.m_waitrequest;
        pending   = read_q && bus.m_waitrequest;
        fifo_pop  = !fifo_empty && bus.pix_ready;
        state_d   = state_q;
        addr_d    = addr_q;
        end_d     = end_q;
        err_d     = err_q;
        flush     = 1'b0;
        start     = 1'b0;
        fifo_push = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) begin
                    start  = 1'b1;
                    addr_d = startpixel;
                    end_d  = endpixel;
                    err_d  = 1'b0;
                    if (endpixel >= startpixel) begin
                        state_d = ISSUE;
                    end else begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (!run && !pending) begin
                    flush   = 1'b1;
                    state_d = IDLE;
                end else if (accept) begin
                    fifo_push = 1'b1;
                    addr_d    = addr_q + ADDR_W'(1);
                    if (addr_q == end_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!run) begin
                    flush   = 1'b1;
                    state_d = IDLE;
                end else if (fifo_empty) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!run) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        count_after = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
        read_d = (state_d == ISSUE) && (pending || (count_after < CNT_W'(FIFO_DEPTH)));
        busy_d = (state_d == ISSUE) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    // All control state and status outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            end_q   <= '0;
            read_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            end_q   <= end_d;
            read_q  <= read_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // The FIFO has no dedicated flush port, so an abort is folded into its reset.
    assign fifo_rst = rst || flush;

    pixel_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (fifo_rst),
        .push  (fifo_push),
        .wdata (bus.m_readdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign bus.m_address = addr_q;
    assign bus.m_read    = read_q;
    assign bus.pix_valid = !fifo_empty;
    assign bus.pix_data  = fifo_rdata;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

`ifdef PIXEL_COUNT_EN
    logic [31:0] pix_count_q, pix_count_d;

    // Counts completed stream handshakes, restarting on every start and
    // sticking at all-ones instead of wrapping.
    always_comb begin
        pix_count_d = pix_count_q;
        if (start) begin
            pix_count_d = '0;
        end else if (fifo_pop && (pix_count_q != 32'hFFFF_FFFF)) begin
            pix_count_d = pix_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_count_q <= '0;
        end else begin
            pix_count_q <= pix_count_d;
        end
    end

    assign pix_count = pix_count_q;
`endif
endmodule

// File: tb/tb_pixel_read_master.sv
// tb_pixel_read_master -- self-checking bench for pixel_read_master.
// The bench plays the memory (data word is a hash of the address) and the
// Sobel stage, and predicts the stream from the range and FIFO depth alone.
// Build option PIXEL_COUNT_EN enables the pix_count checks.
`timescale 1ns/1ps
module tb_pixel_read_master;
    localparam int FIFO_DEPTH = 4;

    logic        clk;
    logic        rst;
    logic [31:0] startpixel;
    logic [31:0] endpixel;
    logic [31:0] control;
    logic        busy, done, err;
`ifdef PIXEL_COUNT_EN
    logic [31:0] pix_count;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;
    int rel_accepted;
    logic rel_read;
    int stall_seen;

    pixel_read_master_if #(.ADDR_W(32), .DATA_W(32)) pix_bus ();

    pixel_read_master #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .startpixel (startpixel),
        .endpixel   (endpixel),
        .control    (control),
        .bus        (pix_bus),
        .busy       (busy),
        .done       (done),
        .err        (err)
`ifdef PIXEL_COUNT_EN
        ,
        .pix_count  (pix_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents seen by the master: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // Runs one frame from start to completion and back to IDLE, checking every
    // cycle against the expected request/stream behaviour.
    // wr_mode: 0 never stall, 1 random stalls, 2 stall 3 cycles at stall_addr.
    // ready_mode: 0 always ready, 1 random; ready held low for ready_hold cycles.
    task automatic run_frame(input logic [31:0] s, input logic [31:0] e, input int wr_mode,
                             input logic [31:0] stall_addr, input int ready_mode, input int ready_hold);
        logic [31:0] exp_q[$];
        logic [31:0] exp_word;
        int n, accepted, popped, occ, cyc, last_pop, stall_left;
        bit fin, wr, rdy, exp_done, exp_read;
        n = int'(e - s) + 1;
        accepted = 0; popped = 0; occ = 0; cyc = 0; last_pop = -10; stall_left = 3;
        fin = 1'b0; stall_seen = 0;
        @(negedge clk);
        startpixel = s;
        endpixel = e;
        control = $urandom | 32'd1;
        pix_bus.m_waitrequest = 1'b0;
        pix_bus.pix_ready = 1'b0;
        while (!fin && cyc < 400) begin
            @(negedge clk);
            cyc++;
            exp_read = (accepted < n) && (occ < FIFO_DEPTH);
            exp_done = (popped == n) && (cyc - last_pop >= 2);
            n_compared++;
            if (pix_bus.m_read !== exp_read) begin
                n_mismatched++;
                $display("[TB] FAIL m_read cyc %0d: got %b, expected %b", cyc, pix_bus.m_read, exp_read);
            end
            if (exp_read) begin
                n_compared++;
                if (pix_bus.m_address !== (s + 32'(accepted))) begin
                    n_mismatched++;
                    $display("[TB] FAIL m_address: got %0h, expected %0h", pix_bus.m_address, s + 32'(accepted));
                end
            end
            n_compared++;
            if (pix_bus.pix_valid !== (occ > 0)) begin
                n_mismatched++;
                $display("[TB] FAIL pix_valid cyc %0d: got %b, expected %b", cyc, pix_bus.pix_valid, occ > 0);
            end
            n_compared++;
            if (done !== exp_done || busy !== !exp_done || err !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL status cyc %0d: got done=%b busy=%b err=%b, expected done=%b busy=%b err=0",
                         cyc, done, busy, err, exp_done, !exp_done);
            end
`ifdef PIXEL_COUNT_EN
            n_compared++;
            if (pix_count !== 32'(popped)) begin
                n_mismatched++;
                $display("[TB] FAIL pix_count: got %0d, expected %0d", pix_count, popped);
            end
`endif
            if (exp_done) begin
                fin = 1'b1;
            end else begin
                wr = 1'b0;
                if (wr_mode == 1) begin
                    wr = ($urandom_range(0, 2) == 0);
                end else if (wr_mode == 2 && pix_bus.m_read && pix_bus.m_address == stall_addr && stall_left > 0) begin
                    wr = 1'b1;
                    stall_left--;
                    stall_seen++;
                end
                if (cyc <= ready_hold) rdy = 1'b0;
                else if (ready_mode == 1) rdy = ($urandom_range(0, 1) == 1);
                else rdy = 1'b1;
                if (cyc == ready_hold) begin
                    rel_accepted = accepted;
                    rel_read = pix_bus.m_read;
                end
                pix_bus.m_waitrequest = wr;
                pix_bus.pix_ready = rdy;
                pix_bus.m_readdata = wr ? $urandom : mem_word(pix_bus.m_address);
                if (pix_bus.pix_valid && rdy) begin
                    n_compared++;
                    if (exp_q.size() == 0) begin
                        n_mismatched++;
                        $display("[TB] FAIL pop_empty: got a pop, expected no pixel available");
                    end else begin
                        exp_word = exp_q.pop_front();
                        if (pix_bus.pix_data !== exp_word) begin
                            n_mismatched++;
                            $display("[TB] FAIL pix_data #%0d: got %0h, expected %0h", popped, pix_bus.pix_data, exp_word);
                        end
                    end
                    popped++;
                    occ--;
                    last_pop = cyc;
                end
                if (pix_bus.m_read && !wr) begin
                    exp_q.push_back(mem_word(s + 32'(accepted)));
                    accepted++;
                    occ++;
                end
            end
        end
        if (!fin) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL frame_timeout: got %0d pixels, expected %0d", popped, n);
        end
        control = $urandom & ~32'd1;
        pix_bus.m_waitrequest = 1'b0;
        pix_bus.pix_ready = 1'b1;
        @(negedge clk);
        n_compared++;
        if (done !== 1'b0 || busy !== 1'b0 || pix_bus.m_read !== 1'b0 || pix_bus.pix_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL back_to_idle: got done=%b busy=%b m_read=%b pix_valid=%b, expected all 0",
                     done, busy, pix_bus.m_read, pix_bus.pix_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        control = '0;
        startpixel = '0;
        endpixel = '0;
        pix_bus.m_waitrequest = 1'b0;
        pix_bus.m_readdata = '0;
        pix_bus.pix_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_compared++;
        if (pix_bus.m_read !== 1'b0 || pix_bus.m_address !== 32'd0 || pix_bus.pix_valid !== 1'b0 ||
            pix_bus.pix_data !== 32'd0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_state: got m_read=%b addr=%0h valid=%b data=%0h busy=%b done=%b err=%b, expected all 0",
                     pix_bus.m_read, pix_bus.m_address, pix_bus.pix_valid, pix_bus.pix_data, busy, done, err);
        end
`ifdef PIXEL_COUNT_EN
        n_compared++;
        if (pix_count !== 32'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_count: got %0d, expected 0", pix_count);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_basic();
        $display("[TB] basic run 10..13");
        run_frame(32'd10, 32'd13, 0, 32'd0, 0, 0);
    endtask

    task automatic test_back_pressure();
        $display("[TB] back-pressure run 0..7");
        run_frame(32'd0, 32'd7, 0, 32'd0, 0, 12);
        n_compared++;
        if (rel_accepted != FIFO_DEPTH || rel_read !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL backpressure_fill: got %0d reads, m_read=%b, expected %0d reads, m_read=0",
                     rel_accepted, rel_read, FIFO_DEPTH);
        end
    endtask

    task automatic test_waitrequest();
        $display("[TB] waitrequest stall on address 5");
        run_frame(32'd3, 32'd8, 2, 32'd5, 0, 0);
        n_compared++;
        if (stall_seen != 3) begin
            n_mismatched++;
            $display("[TB] FAIL stall_cycles: got %0d, expected 3", stall_seen);
        end
    endtask

    task automatic test_bad_range();
        $display("[TB] bad range 20..19");
        @(negedge clk);
        startpixel = 32'd20;
        endpixel = 32'd19;
        control = 32'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_compared++;
            if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0 || pix_bus.m_read !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL bad_range: got done=%b err=%b busy=%b m_read=%b, expected 1 1 0 0",
                         done, err, busy, pix_bus.m_read);
            end
        end
        control = 32'd0;
        @(negedge clk);
        n_compared++;
        if (done !== 1'b0 || err !== 1'b1 || busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL bad_range_idle: got done=%b err=%b busy=%b, expected 0 1 0", done, err, busy);
        end
    endtask

    task automatic test_abort();
        int popped;
        int cyc;
        $display("[TB] abort after 2 pixels");
        @(negedge clk);
        startpixel = 32'd0;
        endpixel = 32'd7;
        control = 32'd1;
        pix_bus.m_waitrequest = 1'b0;
        pix_bus.pix_ready = 1'b1;
        popped = 0;
        cyc = 0;
        while (popped < 2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            pix_bus.m_readdata = mem_word(pix_bus.m_address);
            if (pix_bus.pix_valid) popped++;
        end
        control = 32'd0;
        @(negedge clk);
        n_compared++;
        if (popped != 2 || pix_bus.m_read !== 1'b0 || pix_bus.pix_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL abort: got pops=%0d m_read=%b valid=%b busy=%b done=%b, expected 2 0 0 0 0",
                     popped, pix_bus.m_read, pix_bus.pix_valid, busy, done);
        end
        $display("[TB] abort with a stalled read");
        startpixel = 32'd100;
        endpixel = 32'd107;
        control = 32'd1;
        pix_bus.m_waitrequest = 1'b1;
        pix_bus.m_readdata = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        control = 32'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_compared++;
            if (pix_bus.m_read !== 1'b1 || pix_bus.m_address !== 32'd100 || busy !== 1'b1) begin
                n_mismatched++;
                $display("[TB] FAIL abort_hold: got m_read=%b addr=%0d busy=%b, expected 1 100 1",
                         pix_bus.m_read, pix_bus.m_address, busy);
            end
        end
        pix_bus.m_waitrequest = 1'b0;
        @(negedge clk);
        n_compared++;
        if (pix_bus.m_read !== 1'b0 || pix_bus.pix_valid !== 1'b0 || busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL abort_discard: got m_read=%b valid=%b busy=%b, expected 0 0 0",
                     pix_bus.m_read, pix_bus.pix_valid, busy);
        end
    endtask

    task automatic test_reset_mid_issue();
        $display("[TB] reset during ISSUE");
        @(negedge clk);
        startpixel = 32'd0;
        endpixel = 32'd7;
        control = 32'd1;
        pix_bus.m_waitrequest = 1'b0;
        pix_bus.pix_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pix_bus.m_readdata = mem_word(pix_bus.m_address);
        end
        pix_bus.m_waitrequest = 1'b1;
        @(negedge clk);
        n_compared++;
        if (pix_bus.pix_valid !== 1'b1 || pix_bus.m_read !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL pre_reset: got valid=%b m_read=%b, expected 1 1", pix_bus.pix_valid, pix_bus.m_read);
        end
        rst = 1'b1;
        @(negedge clk);
        n_compared++;
        if (pix_bus.m_read !== 1'b0 || pix_bus.m_address !== 32'd0 || pix_bus.pix_valid !== 1'b0 ||
            pix_bus.pix_data !== 32'd0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL mid_reset: got m_read=%b addr=%0h valid=%b data=%0h busy=%b done=%b err=%b, expected all 0",
                     pix_bus.m_read, pix_bus.m_address, pix_bus.pix_valid, pix_bus.pix_data, busy, done, err);
        end
        control = 32'd0;
        pix_bus.m_waitrequest = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] s;
        int len;
        $display("[TB] randomized frames");
        for (int k = 0; k < 6; k++) begin
            s = $urandom_range(0, 5000);
            len = $urandom_range(1, 9);
            run_frame(s, s + 32'(len - 1), 1, 32'd0, 1, 0);
        end
        run_frame(32'hFFFF_FFFC, 32'hFFFF_FFFF, 1, 32'd0, 1, 0);
        run_frame(32'd77, 32'd77, 0, 32'd0, 0, 0);
    endtask

    task automatic test_back_to_back();
        $display("[TB] back-to-back frames");
        run_frame(32'd200, 32'd202, 0, 32'd0, 0, 0);
        run_frame(32'd300, 32'd305, 1, 32'd0, 1, 0);
    endtask

`ifdef PIXEL_COUNT_EN
    task automatic test_pix_count();
        $display("[TB] pixel counter");
        run_frame(32'd0, 32'd5, 0, 32'd0, 0, 0);
        n_compared++;
        if (pix_count !== 32'd6) begin
            n_mismatched++;
            $display("[TB] FAIL pix_count_total: got %0d, expected 6", pix_count);
        end
        run_frame(32'd40, 32'd41, 0, 32'd0, 0, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_pressure();
        test_waitrequest();
        test_bad_range();
        test_back_to_back();
        test_abort();
        test_reset_mid_issue();
        test_random();
`ifdef PIXEL_COUNT_EN
        test_pix_count();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
